// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_IFU = 1'b0,
        GNT_LSU = 1'b1
    } grant_e;

    // Instruction fetches always go out as 32-bit word reads.
    localparam logic [1:0]  SIZE_W           = 2'b10;
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hdeadbeef;

    // Timeout counter width; a disabled timeout (0) still gets a 1-bit counter.
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the IFU, LSU and memory-side handshakes of the shared memory port.
// The arbiter uses the slave view; the surrounding system drives the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Fetch requester
    logic              io_ifu_reqValid;
    logic [ADDR_W-1:0] io_ifu_addr;
    logic              io_ifu_respValid;
    logic [DATA_W-1:0] io_ifu_rdata;

    // Load/store requester
    logic              io_lsu_reqValid;
    logic [ADDR_W-1:0] io_lsu_addr;
    logic              io_lsu_wen;
    logic [DATA_W-1:0] io_lsu_wdata;
    logic [3:0]        io_lsu_wmask;
    logic [1:0]        io_lsu_size;
    logic              io_lsu_respValid;
    logic [DATA_W-1:0] io_lsu_rdata;

    // Single memory/MMIO responder
    logic              io_mem_reqValid;
    logic [ADDR_W-1:0] io_mem_addr;
    logic              io_mem_wen;
    logic [DATA_W-1:0] io_mem_wdata;
    logic [3:0]        io_mem_wmask;
    logic [1:0]        io_mem_size;
    logic              io_mem_respValid;
    logic [DATA_W-1:0] io_mem_rdata;

    // Status
    logic              io_busy;
    logic              io_timeout;

    modport slave (
        input  io_ifu_reqValid, io_ifu_addr,
        output io_ifu_respValid, io_ifu_rdata,
        input  io_lsu_reqValid, io_lsu_addr, io_lsu_wen, io_lsu_wdata, io_lsu_wmask, io_lsu_size,
        output io_lsu_respValid, io_lsu_rdata,
        output io_mem_reqValid, io_mem_addr, io_mem_wen, io_mem_wdata, io_mem_wmask, io_mem_size,
        input  io_mem_respValid, io_mem_rdata,
        output io_busy, io_timeout
    );

    modport master (
        output io_ifu_reqValid, io_ifu_addr,
        input  io_ifu_respValid, io_ifu_rdata,
        output io_lsu_reqValid, io_lsu_addr, io_lsu_wen, io_lsu_wdata, io_lsu_wmask, io_lsu_size,
        input  io_lsu_respValid, io_lsu_rdata,
        input  io_mem_reqValid, io_mem_addr, io_mem_wen, io_mem_wdata, io_mem_wmask, io_mem_size,
        output io_mem_respValid, io_mem_rdata,
        input  io_busy, io_timeout
    );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker. Bit 0 is the IFU, bit 1 the LSU.
// With both requesting, the one that was not granted last wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  grant_e     last_i,
    output logic [1:0] gnt_onehot_o,
    output grant_e     gnt_idx_o
);

    // Pick the winner and encode it both as an index and as a one-hot vector.
    always_comb begin
        gnt_onehot_o = 2'b00;
        gnt_idx_o    = GNT_IFU;
        if (req_i == 2'b11) begin
            if (last_i == GNT_IFU) begin
                gnt_idx_o = GNT_LSU;
            end else begin
                gnt_idx_o = GNT_IFU;
            end
        end else if (req_i[1]) begin
            gnt_idx_o = GNT_LSU;
        end
        if (req_i != 2'b00) begin
            if (gnt_idx_o == GNT_LSU) begin
                gnt_onehot_o = 2'b10;
            end else begin
                gnt_onehot_o = 2'b01;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch (IFU) and load/store (LSU) requesters.
// One transaction is in flight at a time: IDLE picks a winner and latches its fields,
// ISSUE pulses the memory request, WAIT forwards the response or times out.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
    input  logic               clock,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    localparam int              CNT_W    = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    grant_e            grant_q, grant_d;
    grant_e            last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_wen_q, mem_wen_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wmask_q, mem_wmask_d;
    logic [1:0]        mem_size_q, mem_size_d;

    logic [1:0]        req_vec;
    logic [1:0]        gnt_onehot;
    grant_e            gnt_idx;
    logic              resp_fire;
    logic              timeout_fire;
    logic [DATA_W-1:0] resp_data;

    assign req_vec = {bus.io_lsu_reqValid, bus.io_ifu_reqValid};

    rr_arb2 u_rr_arb2 (
        .req_i        (req_vec),
        .last_i       (last_q),
        .gnt_onehot_o (gnt_onehot),
        .gnt_idx_o    (gnt_idx)
    );

    // Next-state logic: arbitration, field capture, response/timeout handling.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wen_d    = mem_wen_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wmask_d  = mem_wmask_q;
        mem_size_d   = mem_size_q;
        resp_fire    = 1'b0;
        timeout_fire = 1'b0;
        resp_data    = '0;

        case (state_q)
            IDLE: begin
                if (|gnt_onehot) begin
                    state_d = ISSUE;
                    grant_d = gnt_idx;
                    last_d  = gnt_idx;
                    if (gnt_onehot[1]) begin
                        mem_addr_d  = bus.io_lsu_addr;
                        mem_wen_d   = bus.io_lsu_wen;
                        mem_wdata_d = bus.io_lsu_wdata;
                        mem_wmask_d = bus.io_lsu_wmask;
                        mem_size_d  = bus.io_lsu_size;
                    end else begin
                        // Fetches are plain word reads with no write payload.
                        mem_addr_d  = bus.io_ifu_addr;
                        mem_wen_d   = 1'b0;
                        mem_wdata_d = '0;
                        mem_wmask_d = 4'h0;
                        mem_size_d  = SIZE_W;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.io_mem_respValid) begin
                    resp_fire = 1'b1;
                    resp_data = bus.io_mem_rdata;
                    state_d   = IDLE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    // Responder gave up on: answer the requester so it never hangs.
                    resp_fire    = 1'b1;
                    timeout_fire = 1'b1;
                    resp_data    = ERR_DATA;
                    state_d      = IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and field registers with synchronous reset to an all-quiet port.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= GNT_IFU;
            last_q      <= GNT_IFU;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wen_q   <= 1'b0;
            mem_wdata_q <= '0;
            mem_wmask_q <= 4'h0;
            mem_size_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wen_q   <= mem_wen_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            mem_size_q  <= mem_size_d;
        end
    end

    // Memory side: request pulse comes straight from the state, fields from registers.
    assign bus.io_mem_reqValid = (state_q == ISSUE);
    assign bus.io_mem_addr     = mem_addr_q;
    assign bus.io_mem_wen      = mem_wen_q;
    assign bus.io_mem_wdata    = mem_wdata_q;
    assign bus.io_mem_wmask    = mem_wmask_q;
    assign bus.io_mem_size     = mem_size_q;

    // Requester side: only the granted requester sees the pulse; the other stays at zero.
    assign bus.io_ifu_respValid = resp_fire && (grant_q == GNT_IFU);
    assign bus.io_ifu_rdata     = bus.io_ifu_respValid ? resp_data : '0;
    assign bus.io_lsu_respValid = resp_fire && (grant_q == GNT_LSU);
    assign bus.io_lsu_rdata     = bus.io_lsu_respValid ? resp_data : '0;

    assign bus.io_busy    = (state_q != IDLE);
    assign bus.io_timeout = timeout_fire;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle-level reference model compared every cycle,
// directed transactions with literal expectations, then random two-requester traffic.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int          TO   = 8;
    localparam logic [31:0] ERRD = 32'hdeadbeef;
    // Responder returns addr ^ KEY, so address 0x30000000 reads back 0x00000413.
    localparam logic [31:0] KEY  = 32'h30000413;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .TIMEOUT  (TO),
        .ERR_DATA (ERRD)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Memory responder: answers each request after rsp_delay cycles
    // (random 0..5 when rsp_rand, never when rsp_delay < 0).
    // ------------------------------------------------------------------
    int          rsp_delay     = 0;
    bit          rsp_rand      = 1'b0;
    bit          stray_pending = 1'b0;
    int          rsp_cd        = -1;
    logic [31:0] rsp_addr      = '0;

    initial begin
        bus.io_mem_respValid = 1'b0;
        bus.io_mem_rdata     = '0;
        forever begin
            @(negedge clk);
            if (bus.io_mem_reqValid === 1'b1) begin
                rsp_addr = bus.io_mem_addr;
                rsp_cd   = rsp_rand ? int'($urandom_range(0, 5)) : rsp_delay;
            end
            @(posedge clk);
            #1;
            bus.io_mem_respValid = 1'b0;
            bus.io_mem_rdata     = '0;
            if (stray_pending) begin
                bus.io_mem_respValid = 1'b1;
                bus.io_mem_rdata     = 32'h5555aaaa;
                stray_pending        = 1'b0;
            end else if (rsp_cd == 0) begin
                bus.io_mem_respValid = 1'b1;
                bus.io_mem_rdata     = rsp_addr ^ KEY;
                rsp_cd               = -1;
            end else if (rsp_cd > 0) begin
                rsp_cd--;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: a transaction is described by the cycle number of its
    // memory request; responses land in later cycles, timeouts TO cycles after it.
    // ------------------------------------------------------------------
    int          cyc      = 0;
    bit          m_active = 1'b0;
    int          m_issue  = -100;
    grant_e      m_last   = GNT_IFU;
    grant_e      m_who    = GNT_IFU;
    logic [31:0] m_addr   = '0;
    logic        m_wen    = 1'b0;
    logic [31:0] m_wdata  = '0;
    logic [3:0]  m_wmask  = '0;
    logic [1:0]  m_size   = '0;

    bit          e_mreq, e_ir, e_lr, e_to, e_done;
    logic [31:0] e_ird, e_lrd, e_rd;

    int          ifu_pulses = 0, lsu_pulses = 0, mem_reqs = 0, to_pulses = 0;
    logic [31:0] cap_addr = '0, cap_wdata = '0;
    logic        cap_wen  = 1'b0;
    logic [3:0]  cap_wmask = '0;
    logic [1:0]  cap_size  = '0;

    always @(negedge clk) begin : model
        cyc    = cyc + 1;
        e_mreq = m_active && (cyc == m_issue);
        e_ir   = 1'b0;
        e_lr   = 1'b0;
        e_to   = 1'b0;
        e_done = 1'b0;
        e_ird  = '0;
        e_lrd  = '0;
        e_rd   = '0;
        if (m_active && (cyc > m_issue)) begin
            if (bus.io_mem_respValid === 1'b1) begin
                e_done = 1'b1;
                e_rd   = bus.io_mem_rdata;
            end else if ((cyc - m_issue) == TO) begin
                e_done = 1'b1;
                e_rd   = ERRD;
                e_to   = 1'b1;
            end
            if (e_done) begin
                if (m_who == GNT_LSU) begin
                    e_lr  = 1'b1;
                    e_lrd = e_rd;
                end else begin
                    e_ir  = 1'b1;
                    e_ird = e_rd;
                end
            end
        end

        chk("busy",          64'(bus.io_busy),          64'(m_active));
        chk("mem_reqValid",  64'(bus.io_mem_reqValid),  64'(e_mreq));
        chk("mem_addr",      64'(bus.io_mem_addr),      64'(m_addr));
        chk("mem_wen",       64'(bus.io_mem_wen),       64'(m_wen));
        chk("mem_wdata",     64'(bus.io_mem_wdata),     64'(m_wdata));
        chk("mem_wmask",     64'(bus.io_mem_wmask),     64'(m_wmask));
        chk("mem_size",      64'(bus.io_mem_size),      64'(m_size));
        chk("ifu_respValid", 64'(bus.io_ifu_respValid), 64'(e_ir));
        chk("ifu_rdata",     64'(bus.io_ifu_rdata),     64'(e_ird));
        chk("lsu_respValid", 64'(bus.io_lsu_respValid), 64'(e_lr));
        chk("lsu_rdata",     64'(bus.io_lsu_rdata),     64'(e_lrd));
        chk("timeout",       64'(bus.io_timeout),       64'(e_to));

        if (bus.io_mem_reqValid === 1'b1) begin
            mem_reqs++;
            cap_addr  = bus.io_mem_addr;
            cap_wen   = bus.io_mem_wen;
            cap_wdata = bus.io_mem_wdata;
            cap_wmask = bus.io_mem_wmask;
            cap_size  = bus.io_mem_size;
        end
        if (bus.io_ifu_respValid === 1'b1) ifu_pulses++;
        if (bus.io_lsu_respValid === 1'b1) lsu_pulses++;
        if (bus.io_timeout === 1'b1)       to_pulses++;

        if (rst) begin
            m_active = 1'b0;
            m_last   = GNT_IFU;
            m_addr   = '0;
            m_wen    = 1'b0;
            m_wdata  = '0;
            m_wmask  = '0;
            m_size   = '0;
        end else if (e_done) begin
            m_active = 1'b0;
        end else if (!m_active && (bus.io_ifu_reqValid || bus.io_lsu_reqValid)) begin
            if (bus.io_ifu_reqValid && bus.io_lsu_reqValid) begin
                if (m_last == GNT_IFU) m_who = GNT_LSU;
                else                   m_who = GNT_IFU;
            end else if (bus.io_lsu_reqValid) begin
                m_who = GNT_LSU;
            end else begin
                m_who = GNT_IFU;
            end
            m_last   = m_who;
            m_active = 1'b1;
            m_issue  = cyc + 1;
            if (m_who == GNT_LSU) begin
                m_addr  = bus.io_lsu_addr;
                m_wen   = bus.io_lsu_wen;
                m_wdata = bus.io_lsu_wdata;
                m_wmask = bus.io_lsu_wmask;
                m_size  = bus.io_lsu_size;
            end else begin
                m_addr  = bus.io_ifu_addr;
                m_wen   = 1'b0;
                m_wdata = '0;
                m_wmask = 4'h0;
                m_size  = 2'b10;
            end
        end
    end

    // ------------------------------------------------------------------
    // One request from IFU or LSU, held until its response; lat counts cycles
    // from the cycle the request is raised (0) to the response cycle.
    // ------------------------------------------------------------------
    task automatic do_txn(input bit is_lsu, input logic [31:0] a, input logic wen,
                          input logic [31:0] wd, input logic [3:0] wm, input logic [1:0] sz,
                          input int budget, output bit got, output logic [31:0] rd,
                          output int lat, output bit to);
        @(posedge clk);
        #1;
        if (is_lsu) begin
            bus.io_lsu_addr     = a;
            bus.io_lsu_wen      = wen;
            bus.io_lsu_wdata    = wd;
            bus.io_lsu_wmask    = wm;
            bus.io_lsu_size     = sz;
            bus.io_lsu_reqValid = 1'b1;
        end else begin
            bus.io_ifu_addr     = a;
            bus.io_ifu_reqValid = 1'b1;
        end
        got = 1'b0;
        rd  = '0;
        lat = -1;
        to  = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk);
            if (is_lsu ? (bus.io_lsu_respValid === 1'b1) : (bus.io_ifu_respValid === 1'b1)) begin
                got = 1'b1;
                rd  = is_lsu ? bus.io_lsu_rdata : bus.io_ifu_rdata;
                lat = k;
                to  = bus.io_timeout;
            end
        end
        @(posedge clk);
        #1;
        if (is_lsu) bus.io_lsu_reqValid = 1'b0;
        else        bus.io_ifu_reqValid = 1'b0;
        $display("txn %s addr=%08h wen=%0d rdata=%08h latency=%0d timeout=%0d got=%0d",
                 is_lsu ? "LSU" : "IFU", a, wen, rd, lat, to, got);
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Random requester: gap, random fields, check own response data.
    task automatic agent(input bit is_lsu, input int n);
        bit          got, to;
        logic [31:0] a, rd;
        int          lat;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            a = $urandom;
            do_txn(is_lsu, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                   2'($urandom_range(0, 2)), 60, got, rd, lat, to);
            chk(is_lsu ? "rand_lsu_got" : "rand_ifu_got", 64'(got), 64'(1));
            chk(is_lsu ? "rand_lsu_data" : "rand_ifu_data", 64'(rd), 64'(a ^ KEY));
            chk(is_lsu ? "rand_lsu_no_to" : "rand_ifu_no_to", 64'(to), 64'(0));
        end
    endtask

    int          ord[4];
    int          at[4];
    logic [31:0] dat[4];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit          got, to;
        logic [31:0] rd;
        int          lat, n, p0, p1, r0;

        bus.io_ifu_reqValid = 1'b0;
        bus.io_ifu_addr     = '0;
        bus.io_lsu_reqValid = 1'b0;
        bus.io_lsu_addr     = '0;
        bus.io_lsu_wen      = 1'b0;
        bus.io_lsu_wdata    = '0;
        bus.io_lsu_wmask    = '0;
        bus.io_lsu_size     = '0;

        // Reset state
        @(negedge clk);
        chk("rst_busy",      64'(bus.io_busy),         64'(0));
        chk("rst_mem_req",   64'(bus.io_mem_reqValid), 64'(0));
        chk("rst_mem_addr",  64'(bus.io_mem_addr),     64'(0));
        chk("rst_mem_size",  64'(bus.io_mem_size),     64'(0));
        chk("rst_ifu_resp",  64'(bus.io_ifu_respValid), 64'(0));
        chk("rst_timeout",   64'(bus.io_timeout),      64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: IFU fetch alone, zero-wait memory
        p1 = lsu_pulses;
        r0 = mem_reqs;
        do_txn(1'b0, 32'h30000000, 1'b0, '0, '0, '0, 30, got, rd, lat, to);
        chk("t1_got",        64'(got),      64'(1));
        chk("t1_rdata",      64'(rd),       64'(32'h00000413));
        chk("t1_latency",    64'(lat),      64'(2));
        chk("t1_mem_addr",   64'(cap_addr), 64'(32'h30000000));
        chk("t1_mem_wen",    64'(cap_wen),  64'(0));
        chk("t1_mem_size",   64'(cap_size), 64'(2'b10));
        chk("t1_mem_reqs",   64'(mem_reqs - r0),   64'(1));
        chk("t1_lsu_silent", 64'(lsu_pulses - p1), 64'(0));

        // 3: LSU byte store
        r0 = mem_reqs;
        do_txn(1'b1, 32'h10000000, 1'b1, 32'h41, 4'h1, 2'b00, 30, got, rd, lat, to);
        chk("t3_got",       64'(got),       64'(1));
        chk("t3_rdata",     64'(rd),        64'(32'h20000413));
        chk("t3_latency",   64'(lat),       64'(2));
        chk("t3_mem_addr",  64'(cap_addr),  64'(32'h10000000));
        chk("t3_mem_wen",   64'(cap_wen),   64'(1));
        chk("t3_mem_wdata", 64'(cap_wdata), 64'(32'h41));
        chk("t3_mem_wmask", 64'(cap_wmask), 64'(4'h1));
        chk("t3_mem_size",  64'(cap_size),  64'(2'b00));
        chk("t3_mem_reqs",  64'(mem_reqs - r0), 64'(1));

        // 4: memory never answers -> error response 8 cycles after the memory request
        rsp_delay = -1;
        do_txn(1'b0, 32'h00000040, 1'b0, '0, '0, '0, 30, got, rd, lat, to);
        chk("t4_got",     64'(got), 64'(1));
        chk("t4_rdata",   64'(rd),  64'(32'hdeadbeef));
        chk("t4_timeout", 64'(to),  64'(1));
        chk("t4_latency", 64'(lat), 64'(9));
        // Late/stray memory response while idle must not reach a requester
        p0 = ifu_pulses;
        p1 = lsu_pulses;
        stray_pending = 1'b1;
        repeat (5) @(negedge clk);
        chk("t4_stray_ifu", 64'(ifu_pulses - p0), 64'(0));
        chk("t4_stray_lsu", 64'(lsu_pulses - p1), 64'(0));

        // 5: reset in the middle of WAIT
        p0 = ifu_pulses;
        @(posedge clk);
        #1;
        bus.io_ifu_addr     = 32'h00000044;
        bus.io_ifu_reqValid = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5_busy_wait", 64'(bus.io_busy), 64'(1));
        @(posedge clk);
        #1;
        rst                 = 1'b1;
        bus.io_ifu_reqValid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_busy",     64'(bus.io_busy),         64'(0));
        chk("t5_mem_req",  64'(bus.io_mem_reqValid), 64'(0));
        chk("t5_mem_addr", 64'(bus.io_mem_addr),     64'(0));
        chk("t5_no_resp",  64'(ifu_pulses - p0),     64'(0));
        rsp_delay = 0;
        do_txn(1'b0, 32'h00000080, 1'b0, '0, '0, '0, 30, got, rd, lat, to);
        chk("t5_after_got",     64'(got), 64'(1));
        chk("t5_after_rdata",   64'(rd),  64'(32'h30000493));
        chk("t5_after_latency", 64'(lat), 64'(2));

        // 2: both requesters held high after reset -> LSU, IFU, LSU, IFU every 3 cycles
        reset_dut();
        @(posedge clk);
        #1;
        bus.io_ifu_addr     = 32'h00000100;
        bus.io_lsu_addr     = 32'h00000200;
        bus.io_lsu_wen      = 1'b0;
        bus.io_lsu_wdata    = '0;
        bus.io_lsu_wmask    = 4'h0;
        bus.io_lsu_size     = 2'b10;
        bus.io_ifu_reqValid = 1'b1;
        bus.io_lsu_reqValid = 1'b1;
        n = 0;
        for (int k = 0; k < 60 && n < 4; k++) begin
            @(negedge clk);
            if (bus.io_lsu_respValid === 1'b1 && n < 4) begin
                ord[n] = 1; at[n] = k; dat[n] = bus.io_lsu_rdata; n++;
                $display("txn LSU addr=00000200 rdata=%08h cycle=%0d", bus.io_lsu_rdata, k);
            end
            if (bus.io_ifu_respValid === 1'b1 && n < 4) begin
                ord[n] = 0; at[n] = k; dat[n] = bus.io_ifu_rdata; n++;
                $display("txn IFU addr=00000100 rdata=%08h cycle=%0d", bus.io_ifu_rdata, k);
            end
        end
        @(posedge clk);
        #1;
        bus.io_ifu_reqValid = 1'b0;
        bus.io_lsu_reqValid = 1'b0;
        chk("t2_count", 64'(n), 64'(4));
        for (int i = 0; i < n; i++) begin
            chk("t2_order", 64'(ord[i]), 64'((i % 2 == 0) ? 1 : 0));
            chk("t2_cycle", 64'(at[i]),  64'(2 + 3 * i));
            chk("t2_rdata", 64'(dat[i]), 64'((i % 2 == 0) ? 32'h30000613 : 32'h30000513));
        end

        // 6: random concurrent traffic with random responder delay
        rsp_rand = 1'b1;
        p0 = ifu_pulses;
        p1 = lsu_pulses;
        fork
            agent(1'b0, 30);
            agent(1'b1, 30);
        join
        repeat (3) @(negedge clk);
        chk("t6_ifu_pulses", 64'(ifu_pulses - p0), 64'(30));
        chk("t6_lsu_pulses", 64'(lsu_pulses - p1), 64'(30));
        chk("t6_timeouts",   64'(to_pulses),       64'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
